// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-map definitions for the unified 1024x16 RAM and its requesters.
package mem_map_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    REQ_VGA = 2'd0,
    REQ_CPU = 2'd1,
    REQ_IO  = 2'd2
  } req_idx_e;

  // Word addresses the I/O snapshot writer drops controller/music state into.
  localparam logic [ADDR_W-1:0] CTRL_ADDR  = 10'h3F0;
  localparam logic [ADDR_W-1:0] MUSIC_ADDR = 10'h3F1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus the single RAM port, bundled for the arbiter.
interface mem_port_arbiter_if;
  import mem_map_pkg::*;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;

  logic              io_req;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              io_gnt;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rdata;

  // Arbiter side.
  modport slave (
    input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  io_req, io_addr, io_wdata, ram_rdata,
    output vga_gnt, vga_rvalid, cpu_gnt, cpu_rvalid, io_gnt,
    output ram_addr, ram_we, ram_wdata, rdata
  );

  // Requester / RAM side.
  modport master (
    output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output io_req, io_addr, io_wdata, ram_rdata,
    input  vga_gnt, vga_rvalid, cpu_gnt, cpu_rvalid, io_gnt,
    input  ram_addr, ram_we, ram_wdata, rdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin chooser: ptr=0 favours req0, ptr=1 favours req1 on a tie.
module rr_pick2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req0 && (!req1 || !ptr)) begin
      gnt[0] = 1'b1;
    end else if (req1) begin
      gnt[1] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: VGA deadline priority, CPU anti-starvation override,
// CPU/IO round-robin, combinational address/data mux and 1-cycle read valid.
module mem_port_arbiter
  import mem_map_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic       vga_rvalid_q, vga_rvalid_d;
  logic       cpu_rvalid_q, cpu_rvalid_d;

  logic [1:0] rr_gnt;
  logic [2:0] gnt;

  rr_pick2 u_rr_pick2 (
    .req0 (bus.cpu_req),
    .req1 (bus.io_req),
    .ptr  (rr_ptr_q),
    .gnt  (rr_gnt)
  );

  // Grants are held off for the whole time reset is asserted.
  always_comb begin
    gnt = 3'b000;
    if (!reset) begin
      gnt = 3'b000;
    end else if (bus.cpu_req && (wait_cnt_q == MAX_WAIT_C)) begin
      gnt[REQ_CPU] = 1'b1;
    end else if (bus.vga_req) begin
      gnt[REQ_VGA] = 1'b1;
    end else begin
      gnt[REQ_CPU] = rr_gnt[0];
      gnt[REQ_IO]  = rr_gnt[1];
    end
  end

  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    if (gnt[REQ_VGA]) begin
      bus.ram_addr = bus.vga_addr;
    end else if (gnt[REQ_CPU]) begin
      bus.ram_addr  = bus.cpu_addr;
      bus.ram_we    = bus.cpu_we;
      bus.ram_wdata = bus.cpu_wdata;
    end else if (gnt[REQ_IO]) begin
      bus.ram_addr  = bus.io_addr;
      bus.ram_we    = 1'b1;
      bus.ram_wdata = bus.io_wdata;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt[REQ_CPU]) begin
      rr_ptr_d = 1'b1;
    end else if (gnt[REQ_IO]) begin
      rr_ptr_d = 1'b0;
    end

    // Any denial of a pending CPU request counts, whoever won the port.
    wait_cnt_d = wait_cnt_q;
    if (!bus.cpu_req || gnt[REQ_CPU]) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end

    vga_rvalid_d = gnt[REQ_VGA];
    cpu_rvalid_d = gnt[REQ_CPU] & ~bus.cpu_we;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q   <= 8'd0;
      rr_ptr_q     <= 1'b0;
      vga_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      vga_rvalid_q <= vga_rvalid_d;
      cpu_rvalid_q <= cpu_rvalid_d;
    end
  end

  assign bus.vga_gnt    = gnt[REQ_VGA];
  assign bus.cpu_gnt    = gnt[REQ_CPU];
  assign bus.io_gnt     = gnt[REQ_IO];
  assign bus.vga_rvalid = vga_rvalid_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.rdata      = bus.ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a behavioural 1024x16 RAM.
module tb_mem_port_arbiter;
  import mem_map_pkg::*;

  logic clk;
  logic reset;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_WAIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  gnt;   // {io, cpu, vga}
    logic        we;
    logic [9:0]  addr;
    logic [15:0] wd;
  } cyc_exp_t;

  typedef struct {
    logic        is_cpu;
    logic [15:0] data;
  } rd_exp_t;

  cyc_exp_t exp_q[$];
  rd_exp_t  rd_q[$];
  cyc_exp_t e;
  rd_exp_t  r;
  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;

  // RAM model: 1-cycle read latency, contents reloaded while reset is low.
  logic [15:0] mem [0:1023];

  function automatic logic [15:0] init_val(input int a);
    if (a == 'h010) return 16'hBEEF;
    return 16'hA000 | 16'(a);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 1024; k++) mem[k] <= init_val(k);
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  // Monitor: per-cycle bus expectations and the read-data scoreboard.
  always @(negedge clk) begin
    cyc_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.io_gnt, bus.cpu_gnt, bus.vga_gnt} !== e.gnt || bus.ram_we !== e.we ||
          bus.ram_addr !== e.addr || bus.ram_wdata !== e.wd) begin
        failures++;
        $display("FAIL bus_cycle t=%0t gnt=%b we=%b addr=%h wd=%h required gnt=%b we=%b addr=%h wd=%h",
                 $time, {bus.io_gnt, bus.cpu_gnt, bus.vga_gnt}, bus.ram_we, bus.ram_addr,
                 bus.ram_wdata, e.gnt, e.we, e.addr, e.wd);
      end else begin
        $display("bus_cycle t=%0t gnt=%b we=%b addr=%h wd=%h ok", $time,
                 e.gnt, e.we, e.addr, e.wd);
      end
    end
    if (bus.vga_rvalid || bus.cpu_rvalid) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rvalid t=%0t vga_rvalid=%b cpu_rvalid=%b required none",
                 $time, bus.vga_rvalid, bus.cpu_rvalid);
      end else begin
        r = rd_q.pop_front();
        if ((bus.vga_rvalid && bus.cpu_rvalid) || bus.cpu_rvalid !== r.is_cpu ||
            bus.rdata !== r.data) begin
          failures++;
          $display("FAIL read_data t=%0t vga_rvalid=%b cpu_rvalid=%b rdata=%h required cpu=%b rdata=%h",
                   $time, bus.vga_rvalid, bus.cpu_rvalid, bus.rdata, r.is_cpu, r.data);
        end else begin
          $display("read t=%0t cpu=%b rdata=%h ok", $time, r.is_cpu, r.data);
        end
      end
    end
  end

  // Drive one cycle of requests and queue what that cycle must produce.
  task automatic cyc(input logic v, input logic [9:0] va,
                     input logic c, input logic cwe, input logic [9:0] ca, input logic [15:0] cwd,
                     input logic i, input logic [9:0] ia, input logic [15:0] iwd,
                     input logic [2:0] eg, input logic ewe, input logic [9:0] eaddr,
                     input logic [15:0] ewd, input logic push_rd, input logic [15:0] erd);
    cyc_exp_t ce;
    rd_exp_t  re;
    bus.vga_req = v;  bus.vga_addr = va;
    bus.cpu_req = c;  bus.cpu_we = cwe; bus.cpu_addr = ca; bus.cpu_wdata = cwd;
    bus.io_req  = i;  bus.io_addr = ia; bus.io_wdata = iwd;
    ce.gnt = eg; ce.we = ewe; ce.addr = eaddr; ce.wd = ewd;
    exp_q.push_back(ce);
    if (push_rd) begin
      re.is_cpu = eg[1];
      re.data   = erd;
      rd_q.push_back(re);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int k;
    int io_n;
    reset = 1'b0;
    bus.vga_req = 0; bus.vga_addr = 0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.io_req = 0;  bus.io_addr = 0; bus.io_wdata = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // CPU reads and IO snapshot writes contend: strict alternation from rr_ptr=0.
    io_n = 0;
    for (int n = 0; n < 6; n++) begin
      if (n % 2 == 0)
        cyc(0, 0, 1, 0, 10'h010, 0, 1, CTRL_ADDR, 16'h5A00 + 16'(io_n),
            3'b010, 0, 10'h010, 16'h0000, 1, 16'hBEEF);
      else begin
        cyc(0, 0, 1, 0, 10'h010, 0, 1, CTRL_ADDR, 16'h5A00 + 16'(io_n),
            3'b100, 1, CTRL_ADDR, 16'h5A00 + 16'(io_n), 0, 0);
        io_n++;
      end
    end

    // Lone CPU read, then two idle cycles.
    cyc(0, 0, 1, 0, 10'h010, 0, 0, 0, 0, 3'b010, 0, 10'h010, 0, 1, 16'hBEEF);
    idle();
    idle();

    // CPU write (no rvalid), then read back through the RAM.
    cyc(0, 0, 1, 1, 10'h020, 16'h1234, 0, 0, 0, 3'b010, 1, 10'h020, 16'h1234, 0, 0);
    idle();
    cyc(0, 0, 1, 0, 10'h020, 0, 0, 0, 0, 3'b010, 0, 10'h020, 0, 1, 16'h1234);
    idle();

    // VGA streaming with a pending CPU read: override exactly at cycles 8 and 17.
    k = 0;
    for (int n = 0; n < 18; n++) begin
      if (n == 8 || n == 17)
        cyc(1, 10'h100 + 10'(k), 1, 0, 10'h010, 0, 0, 0, 0,
            3'b010, 0, 10'h010, 0, 1, 16'hBEEF);
      else begin
        cyc(1, 10'h100 + 10'(k), 1, 0, 10'h010, 0, 0, 0, 0,
            3'b001, 0, 10'h100 + 10'(k), 0, 1, 16'hA100 + 16'(k));
        k++;
      end
    end
    idle();

    // VGA read granted, reset lands on the cycle its rvalid would show.
    cyc(1, 10'h100, 1, 0, 10'h010, 0, 1, CTRL_ADDR, 16'h7777,
        3'b001, 0, 10'h100, 0, 0, 0);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.vga_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rvalid_on_reset vga_rvalid=%b required 0", bus.vga_rvalid);
    end else begin
      $display("rvalid_on_reset vga_rvalid=0 ok");
    end
    cyc(1, 10'h100, 1, 0, 10'h010, 0, 1, CTRL_ADDR, 16'h7777,
        3'b000, 0, 0, 0, 0, 0);
    reset = 1'b1;
    cyc(1, 10'h100, 1, 0, 10'h010, 0, 1, CTRL_ADDR, 16'h7777,
        3'b001, 0, 10'h100, 0, 1, 16'hA100);
    cyc(0, 0, 1, 0, 10'h010, 0, 1, CTRL_ADDR, 16'h7777,
        3'b010, 0, 10'h010, 0, 1, 16'hBEEF);
    idle();
    idle();

    checks++;
    if (exp_q.size() != 0 || rd_q.size() != 0) begin
      failures++;
      $display("FAIL queues_drained bus_left=%0d reads_left=%0d required 0 0",
               exp_q.size(), rd_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
